// File: rtl/i4_ctx_writeback.sv
// Collects the sixteen reconstructed 4x4 luma sub-blocks of a macroblock, keeps its
// right column / bottom row / corner as neighbour context and writes the bottom row out.
module i4_ctx_writeback #(
  parameter int MBX_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MBX_W-1:0]   mb_x,
  input  logic               abort,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [3:0]         blk_i4,
  input  logic [127:0]       blk_data,
  output logic               lb_wr_en,
  input  logic               lb_wr_ready,
  output logic [MBX_W-1:0]   lb_wr_addr,
  output logic [127:0]       lb_wr_data,
  output logic [127:0]       ctx_left,
  output logic [7:0]         ctx_corner,
  output logic               ctx_valid,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [MBX_W-1:0]   mbx_q, mbx_d;
  logic [127:0]       left_q, left_d;
  logic [127:0]       bot_q, bot_d;
  logic [7:0]         corner_q, corner_d;
  logic               ctx_valid_q, ctx_valid_d;
  logic               err_q, err_d;

  logic               xfer;
  logic               wr_acc;
  logic [1:0]         bx, by;
  logic [6:0]         left_lsb, bot_lsb;
  logic               blk_unused;

  // abort wins over any coincident handshake
  assign xfer     = (state_q == S_COLLECT) && blk_valid && !abort;
  assign wr_acc   = (state_q == S_WRITE) && lb_wr_ready && !abort;
  assign bx       = cnt_q[1:0];
  assign by       = cnt_q[3:2];
  assign left_lsb = {by, 5'b0};
  assign bot_lsb  = {bx, 5'b0};
  assign blk_unused = ^blk_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mbx_q       <= '0;
      left_q      <= '0;
      bot_q       <= '0;
      corner_q    <= '0;
      ctx_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mbx_q       <= mbx_d;
      left_q      <= left_d;
      bot_q       <= bot_d;
      corner_q    <= corner_d;
      ctx_valid_q <= ctx_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start) state_d = S_COLLECT;
        S_COLLECT: if (xfer && cnt_q == 4'd15) state_d = S_WRITE;
        S_WRITE:   if (lb_wr_ready) state_d = S_DONE;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    mbx_d       = mbx_q;
    left_d      = left_q;
    bot_d       = bot_q;
    corner_d    = corner_q;
    ctx_valid_d = ctx_valid_q;
    err_d       = err_q;
    if (abort) begin
      cnt_d = '0;
    end else if (state_q == S_IDLE && start) begin
      cnt_d       = '0;
      err_d       = 1'b0;
      ctx_valid_d = 1'b0;
      mbx_d       = mb_x;
    end else if (xfer) begin
      cnt_d = cnt_q + 4'd1;
      // placement follows the internal count; a wrong index only flags err
      if (blk_i4 != cnt_q) err_d = 1'b1;
      if (bx == 2'd3)
        left_d[left_lsb +: 32] = {blk_data[127:120], blk_data[95:88],
                                  blk_data[63:56], blk_data[31:24]};
      if (by == 2'd3)
        bot_d[bot_lsb +: 32] = blk_data[127:96];
      if (cnt_q == 4'd15)
        corner_d = blk_data[127:120];
    end else if (wr_acc) begin
      ctx_valid_d = 1'b1;
    end
  end

  always_comb begin
    blk_ready  = (state_q == S_COLLECT);
    lb_wr_en   = (state_q == S_WRITE) && !abort;
    done       = (state_q == S_DONE) && !abort;
    lb_wr_addr = mbx_q;
    lb_wr_data = bot_q;
    ctx_left   = left_q;
    ctx_corner = corner_q;
    ctx_valid  = ctx_valid_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_i4_ctx_writeback.sv
// Scoreboard bench for i4_ctx_writeback: expected line-buffer writes are queued when a
// macroblock is driven and matched when the write handshake occurs.
module tb_i4_ctx_writeback;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [9:0]   mb_x;
  logic         abort;
  logic         blk_valid;
  logic         blk_ready;
  logic [3:0]   blk_i4;
  logic [127:0] blk_data;
  logic         lb_wr_en;
  logic         lb_wr_ready;
  logic [9:0]   lb_wr_addr;
  logic [127:0] lb_wr_data;
  logic [127:0] ctx_left;
  logic [7:0]   ctx_corner;
  logic         ctx_valid;
  logic         done;
  logic         err;

  i4_ctx_writeback #(.MBX_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mb_x(mb_x), .abort(abort),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_i4(blk_i4), .blk_data(blk_data),
    .lb_wr_en(lb_wr_en), .lb_wr_ready(lb_wr_ready), .lb_wr_addr(lb_wr_addr),
    .lb_wr_data(lb_wr_data), .ctx_left(ctx_left), .ctx_corner(ctx_corner),
    .ctx_valid(ctx_valid), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]   addr;
    logic [127:0] data;
  } wr_t;

  wr_t          exp_q[$];
  logic [127:0] blks[16];
  int           checks = 0;
  int           errors = 0;
  int           wr_count = 0;
  int           done_count = 0;

  // write monitor: handshake visible mid-cycle completes at the next rising edge
  always @(negedge clk) begin
    if (rst_n && lb_wr_en && lb_wr_ready && !abort) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h", lb_wr_addr, lb_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (lb_wr_addr !== e.addr || lb_wr_data !== e.data) begin
          errors++;
          $display("FAIL wr_beat got addr=%0d data=%h want addr=%0d data=%h",
                   lb_wr_addr, lb_wr_data, e.addr, e.data);
        end
      end
    end
    if (rst_n && done) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] model_bot();
    logic [127:0] r;
    logic [127:0] b;
    for (int c = 0; c < 16; c++) begin
      b = blks[12 + c / 4];
      r[8*c +: 8] = b[8*(12 + c % 4) +: 8];
    end
    return r;
  endfunction

  function automatic logic [127:0] model_left();
    logic [127:0] r;
    logic [127:0] b;
    for (int k = 0; k < 16; k++) begin
      b = blks[4*(k / 4) + 3];
      r[8*k +: 8] = b[8*(4*(k % 4) + 3) +: 8];
    end
    return r;
  endfunction

  function automatic logic [7:0] model_corner();
    logic [127:0] b;
    b = blks[15];
    return b[127:120];
  endfunction

  task automatic fill_pattern();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        blks[i][8*j +: 8] = 8'(16*i + j);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++)
      blks[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic push_exp(input logic [9:0] a);
    wr_t e;
    e.addr = a;
    e.data = model_bot();
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [9:0] a);
    start = 1'b1;
    mb_x  = a;
    tick();
    start = 1'b0;
  endtask

  task automatic send_blocks(input int first, input int last, input bit gaps,
                             input int bad_idx, input logic [3:0] bad_val);
    int n;
    for (int k = first; k <= last; k++) begin
      if (gaps) begin
        blk_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      blk_valid = 1'b1;
      blk_data  = blks[k];
      blk_i4    = (k == bad_idx) ? bad_val : 4'(k);
      n = 0;
      while (!blk_ready && n < 20) begin
        tick();
        n++;
      end
      if (n >= 20) begin
        checks++;
        errors++;
        $display("FAIL blk_ready_timeout blk=%0d got 0 want 1", k);
      end
      tick();
    end
    blk_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got 0 want 1");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({blk_ready, lb_wr_en, done, err, ctx_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {blk_ready, lb_wr_en, done, err, ctx_valid});
    end
    checks++;
    if (ctx_left !== 128'h0 || ctx_corner !== 8'h0 || lb_wr_data !== 128'h0 || lb_wr_addr !== 10'h0) begin
      errors++;
      $display("FAIL reset_data got left=%h corner=%h wdata=%h addr=%0d want 0",
               ctx_left, ctx_corner, lb_wr_data, lb_wr_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [127:0] eb, el;
    int w0, d0;
    fill_pattern();
    for (int c = 0; c < 16; c++) eb[8*c +: 8] = 8'(16*(12 + c/4) + 12 + (c % 4));
    for (int r = 0; r < 16; r++) el[8*r +: 8] = 8'(16*(4*(r/4) + 3) + 4*(r % 4) + 3);
    w0 = wr_count;
    d0 = done_count;
    do_start(10'd5);
    push_exp(10'd5);
    send_blocks(0, 15, 1'b0, -1, 4'd0);
    checks++;
    if (lb_wr_en !== 1'b1 || blk_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_write_state got en=%b rdy=%b want en=1 rdy=0", lb_wr_en, blk_ready);
    end
    checks++;
    if (lb_wr_data !== eb || lb_wr_addr !== 10'd5) begin
      errors++;
      $display("FAIL basic_wdata got %h addr=%0d want %h addr=5", lb_wr_data, lb_wr_addr, eb);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_latency got %b want 1", done);
    end
    checks++;
    if (ctx_left !== el || ctx_corner !== 8'hFF || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_ctx got left=%h corner=%h err=%b want left=%h corner=ff err=0",
               ctx_left, ctx_corner, err, el);
    end
    tick();
    checks++;
    if (done !== 1'b0 || ctx_valid !== 1'b1 || wr_count - w0 != 1 || done_count - d0 != 1) begin
      errors++;
      $display("FAIL basic_after got done=%b vld=%b writes=%0d dones=%0d want 0 1 1 1",
               done, ctx_valid, wr_count - w0, done_count - d0);
    end
  endtask

  task automatic test_backpressure();
    int w0;
    fill_random();
    w0 = wr_count;
    lb_wr_ready = 1'b0;
    do_start(10'd77);
    push_exp(10'd77);
    send_blocks(0, 15, 1'b1, -1, 4'd0);
    blk_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (lb_wr_en !== 1'b1 || blk_ready !== 1'b0 || lb_wr_addr !== 10'd77 || lb_wr_data !== model_bot()) begin
        errors++;
        $display("FAIL bp_stall%0d got en=%b rdy=%b addr=%0d data=%h want en=1 rdy=0 addr=77 data=%h",
                 s, lb_wr_en, blk_ready, lb_wr_addr, lb_wr_data, model_bot());
      end
      tick();
    end
    blk_valid = 1'b0;
    lb_wr_ready = 1'b1;
    tick();
    checks++;
    if (done !== 1'b1 || wr_count - w0 != 1) begin
      errors++;
      $display("FAIL bp_done got done=%b writes=%0d want 1 1", done, wr_count - w0);
    end
    checks++;
    if (ctx_left !== model_left() || ctx_corner !== model_corner()) begin
      errors++;
      $display("FAIL bp_ctx got left=%h corner=%h want left=%h corner=%h",
               ctx_left, ctx_corner, model_left(), model_corner());
    end
    tick();
  endtask

  task automatic test_mismatch();
    fill_random();
    do_start(10'd12);
    push_exp(10'd12);
    send_blocks(0, 5, 1'b0, 5, 4'd7);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL mm_err_set got %b want 1", err);
    end
    send_blocks(6, 15, 1'b0, -1, 4'd0);
    wait_done();
    checks++;
    if (err !== 1'b1 || ctx_left !== model_left()) begin
      errors++;
      $display("FAIL mm_err_sticky got err=%b left=%h want err=1 left=%h", err, ctx_left, model_left());
    end
    tick();
    do_start(10'd13);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL mm_err_clear got %b want 0", err);
    end
    push_exp(10'd13);
    send_blocks(0, 15, 1'b0, -1, 4'd0);
    wait_done();
    tick();
  endtask

  task automatic test_abort();
    int w0, d0;
    fill_random();
    w0 = wr_count;
    d0 = done_count;
    do_start(10'd40);
    send_blocks(0, 8, 1'b0, -1, 4'd0);
    abort = 1'b1;
    blk_valid = 1'b1;
    tick();
    abort = 1'b0;
    repeat (4) tick();
    blk_valid = 1'b0;
    checks++;
    if (blk_ready !== 1'b0 || lb_wr_en !== 1'b0 || wr_count != w0 || done_count != d0) begin
      errors++;
      $display("FAIL abort_collect got rdy=%b en=%b writes=%0d dones=%0d want 0 0 0 0",
               blk_ready, lb_wr_en, wr_count - w0, done_count - d0);
    end
    fill_random();
    do_start(10'd6);
    push_exp(10'd6);
    send_blocks(0, 15, 1'b0, -1, 4'd0);
    wait_done();
    checks++;
    if (ctx_left !== model_left() || ctx_corner !== model_corner()) begin
      errors++;
      $display("FAIL abort_next_ctx got left=%h corner=%h want %h %h",
               ctx_left, ctx_corner, model_left(), model_corner());
    end
    tick();
    d0 = done_count;
    lb_wr_ready = 1'b0;
    do_start(10'd8);
    send_blocks(0, 15, 1'b0, -1, 4'd0);
    abort = 1'b1;
    lb_wr_ready = 1'b1;
    #1;
    checks++;
    if (lb_wr_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_wr_comb got en=%b done=%b want 0 0", lb_wr_en, done);
    end
    tick();
    abort = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || ctx_valid !== 1'b0 || lb_wr_en !== 1'b0 || done_count != d0) begin
      errors++;
      $display("FAIL abort_wr got done=%b vld=%b en=%b dones=%0d want 0 0 0 0",
               done, ctx_valid, lb_wr_en, done_count - d0);
    end
  endtask

  task automatic test_ignored_start();
    fill_random();
    do_start(10'd3);
    push_exp(10'd3);
    send_blocks(0, 4, 1'b0, -1, 4'd0);
    start = 1'b1;
    mb_x  = 10'd9;
    tick();
    start = 1'b0;
    send_blocks(5, 15, 1'b0, -1, 4'd0);
    checks++;
    if (lb_wr_addr !== 10'd3) begin
      errors++;
      $display("FAIL ign_start_addr got %0d want 3", lb_wr_addr);
    end
    wait_done();
    tick();
  endtask

  task automatic test_async_reset();
    fill_random();
    do_start(10'd4);
    send_blocks(0, 6, 1'b0, -1, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({blk_ready, lb_wr_en, done, err, ctx_valid} !== 5'b0 || ctx_left !== 128'h0 ||
        ctx_corner !== 8'h0 || lb_wr_addr !== 10'h0 || lb_wr_data !== 128'h0) begin
      errors++;
      $display("FAIL async_reset got ctrl=%b left=%h addr=%0d want 0",
               {blk_ready, lb_wr_en, done, err, ctx_valid}, ctx_left, lb_wr_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    blk_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (blk_ready !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_ready%0d got %b want 0", s, blk_ready);
      end
    end
    blk_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = wr_count;
    fill_random();
    do_start(10'd0);
    push_exp(10'd0);
    send_blocks(0, 15, 1'b0, -1, 4'd0);
    wait_done();
    checks++;
    if (ctx_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_vld got %b want 1", ctx_valid);
    end
    tick();
    fill_random();
    do_start(10'd1023);
    checks++;
    if (ctx_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_vld_drop got %b want 0", ctx_valid);
    end
    push_exp(10'd1023);
    send_blocks(0, 15, 1'b0, -1, 4'd0);
    checks++;
    if (ctx_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_vld_hold_low got %b want 0", ctx_valid);
    end
    wait_done();
    checks++;
    if (ctx_valid !== 1'b1 || ctx_corner !== model_corner() || wr_count - w0 != 2) begin
      errors++;
      $display("FAIL b2b_second got vld=%b corner=%h writes=%0d want 1 %h 2",
               ctx_valid, ctx_corner, wr_count - w0, model_corner());
    end
    tick();
  endtask

  initial begin
    start = 1'b0;
    mb_x = '0;
    abort = 1'b0;
    blk_valid = 1'b0;
    blk_i4 = '0;
    blk_data = '0;
    lb_wr_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_mismatch();
    test_abort();
    test_ignored_start();
    test_async_reset();
    test_back_to_back();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i4_ctx_writeback.md
Name: i4_ctx_writeback

Overview:
- Collects the sixteen reconstructed 4x4 luma sub-blocks of one macroblock as they leave the intra-4x4 reconstruction loop.
- Extracts the macroblock's right column, bottom row and bottom-right corner as neighbour context for later macroblocks.
- Writes the bottom row to the top-row line buffer at the macroblock's column address, so the next MB row can fetch it as its top context.
- It is the producer counterpart of the I4 neighbour-context rotator, which consumes top/left context.

Parameters:
- MBX_W, 10, width of macroblock column address (line buffer depth 2^MBX_W)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a macroblock
- mb_x  in  MBX_W  macroblock column; sampled on start
- abort  in  1  synchronous abort; returns to IDLE
- blk_valid  in  1  sub-block data valid
- blk_ready  out  1  block accepts sub-block
- blk_i4  in  4  sub-block index presented by the source
- blk_data  in  128  reconstructed 4x4; pixel (r,c) at bits [8*(4r+c)+7 : 8*(4r+c)]
- lb_wr_en  out  1  line-buffer write request
- lb_wr_ready  in  1  line buffer accepts write
- lb_wr_addr  out  MBX_W  write address (= latched mb_x)
- lb_wr_data  out  128  bottom row; byte c = MB pixel (15,c)
- ctx_left  out  128  byte r = MB pixel (r,15)
- ctx_corner  out  8  MB pixel (15,15)
- ctx_valid  out  1  context outputs valid
- done  out  1  one-cycle pulse on write completion
- err  out  1  sticky index-mismatch flag

Behaviour:
- Reset: all state and outputs 0; state IDLE, counter 0, mb_x latch 0.
- States:
  - IDLE: start -> COLLECT. On the start cycle: cnt=0, err=0, ctx_valid=0, mb_x latched.
  - COLLECT: blk_ready=1. A transfer occurs when blk_valid&blk_ready.
    - Each transfer stores data at position cnt, with bx=cnt[1:0], by=cnt[3:2].
    - Sub-blocks arrive in raster order within the MB: i4 = 4*by+bx.
    - Transfer with cnt=15 -> WRITE; otherwise cnt+1.
  - WRITE: lb_wr_en=1. lb_wr_addr and lb_wr_data are stable while lb_wr_en=1 and !lb_wr_ready. On lb_wr_en&lb_wr_ready -> DONE.
  - DONE: done=1 for one cycle, ctx_valid set to 1 -> IDLE.
- Capture rules:
  - bx==3: ctx_left bytes 4*by..4*by+3 <= blk_data bytes 3,7,11,15, i.e. column 3 of rows 0..3.
  - by==3: bottom-row register bytes 4*bx..4*bx+3 <= blk_data[127:96].
  - cnt==15: ctx_corner <= blk_data[127:120].
  - Other sub-blocks are accepted and discarded; no full-MB storage.
- blk_i4 check: if blk_i4 != cnt on a transfer, err is set. Data is still placed by cnt, not by blk_i4. err clears only on start or reset.
- blk_ready is 0 in IDLE, WRITE and DONE; blk_valid in those states is ignored and nothing is consumed.
- start outside IDLE is ignored (no restart, mb_x not re-latched).
- abort (any state): next state IDLE, cnt=0, lb_wr_en=0, no done. ctx_valid stays 0 if aborted before DONE.
  - abort has priority over a coincident transfer or lb_wr_ready; that beat is not consumed and no write is counted.
- ctx_left, ctx_corner and ctx_valid hold until the next start.
- Latency: last sub-block accepted at cycle T. lb_wr_en=1 from T+1. With lb_wr_ready=1 at T+1, done=1 at T+2. Each stall cycle adds 1.
- lb_wr_data reflects the fully assembled bottom row; no partial writes.

Test Plan:
- Basic MB:
  - Stimulus: start with mb_x=5; 16 back-to-back blocks, blk_i4=cnt; every byte = 16*i4+(4r+c); lb_wr_ready=1.
  - Required: one write, addr 5. lb_wr_data byte c = 16*(12+c/4)+12+(c%4).
  - Required: ctx_left byte r = 16*(4*(r/4)+3)+4*(r%4)+3; ctx_corner=0xFF; done at T+2; err=0.
- Backpressure:
  - Stimulus: random blk_valid gaps; lb_wr_ready low 3 cycles.
  - Required: lb_wr_en held with stable addr/data; exactly one write; done 1 cycle after accept; blk_ready=0 during WRITE.
- Index mismatch:
  - Stimulus: 6th block presented with blk_i4=7.
  - Required: err=1 and sticky through done; data placed at position 5; the next start clears err.
- Abort:
  - Stimulus: abort after 9 transfers, then start mb_x=6 with a full MB.
  - Required: no write, no done after the abort; next MB writes addr 6 with correct data.
  - Abort coincident with lb_wr_ready: no done, ctx_valid=0.
- Ignored start and reset:
  - Stimulus: start with mb_x=9 during COLLECT.
  - Required: ignored; write goes to the original mb_x.
  - Stimulus: rst_n low mid-COLLECT.
  - Required: all outputs 0 immediately (asynchronous); blk_ready=0 until the next start.
- Back-to-back MBs:
  - Stimulus: start issued the cycle after done, mb_x=0 then mb_x=1023.
  - Required: two writes to addresses 0 and 1023; ctx_valid drops on the second start and rises at the second done.
